password_lock_top: RTL and testbench
====================================

# password_lock_top

Top level of a 3-digit keypad password lock for an FPGA board. It scans a 4×4 matrix keypad, stores a password set by the user, and checks trial entries against it. It also drives an 8-digit multiplexed seven-segment display and status LEDs (armed/open, failure count). Module name: `password_lock_top`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 8: cycles a key-down or key-up must be stable before it is accepted.
- `DISP_DIV`, default 4: clock cycles per display digit slot.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `set_password` in 1: button; a rising edge enters set mode.
- `enter` in 1: button; a rising edge confirms the current entry.
- `test` in 1: button; a rising edge enters trial (unlock) mode.
- `row` in 4: keypad rows, active-low; 1111 means no key.
- `col` out 4: keypad column drive, one-hot active-low.
- `led_en` out 8: digit enables, one-hot active-low; bit 0 is the rightmost digit.
- `led_ca`…`led_cg`, `led_dp` out 1 each: segment outputs, active-low; `led_dp` is held 1.
- `gled0` out 1: password armed.
- `gled1` out 1: lock open.
- `rled0`, `rled1`, `rled2` out 1 each: failure-count thermometer (≥1, ≥2, ≥3).

## Operation
- Buttons: each of the three inputs is registered. Action occurs on the cycle after a detected 0→1 edge. If edges coincide, priority is set_password > test > enter, and only one action is taken.
- Keypad scanner:
  - While `row`==1111, `col` rotates 1110→1101→1011→0111→1110 every cycle.
  - When any row bit is low, `col` freezes.
  - If the row pattern stays constant and non-1111 for `DEBOUNCE_CYCLES` cycles, one key event is issued. Key code = 4·i + j, where i is the lowest index with row[i]=0 and j is the index of the low `col` bit.
  - No further event is issued until `row`==1111 has held for `DEBOUNCE_CYCLES` cycles; scanning then resumes.
  - A press shorter than `DEBOUNCE_CYCLES` produces no event.
- Entry buffer: 3 hex digits plus a count (0–3).
  - A key event shifts the key code in from the right (new digit → position 0) and increments the count.
  - Key events are ignored when the count is 3 or the state is not SET or TEST.
  - The buffer is cleared on entry to SET or TEST.
- FSM (states IDLE, SET, ARMED, TEST, OPEN, LOCKED):
  - set_password edge: from any state except LOCKED → SET. Clears the buffer, gled0 and gled1.
  - SET + enter with count==3: password ← buffer, failure count ← 0 → ARMED.
  - test edge: from ARMED or OPEN → TEST. Ignored in IDLE, SET and LOCKED.
  - TEST + enter with count==3:
    - Match → OPEN, failure count ← 0.
    - Mismatch → failure count +1 → ARMED.
    - If the count reaches 3 → LOCKED (see Configuration).
  - Enter with count<3 is ignored; state and buffer are unchanged.
  - LOCKED is left only by reset.
- LEDs: gled0 = state∈{ARMED, TEST, OPEN}; gled1 = state==OPEN; rled0/1/2 = failure count ≥1/≥2/≥3.
- Display:
  - Digits 2..0 show the buffer in hex; positions at or above the count are blank.
  - Digit 7 shows the state code: IDLE 0, SET 1, ARMED 2, TEST 3, OPEN 4, LOCKED 5.
  - Digits 6..3 are blank (all segments 1).
  - Hex font is the standard font (b, d lowercase).

## Timing
- Reset values: `col`=1110, `led_en`=11111110, all segments 1, all LEDs 0, state IDLE, password 000, buffer empty, failure count 0.
- Key event is issued `DEBOUNCE_CYCLES` cycles after `row` stabilises low. The buffer updates 1 cycle after the event.
- Button edge to state/LED change: 2 cycles (1-cycle input register + 1-cycle FSM update).
- The display advances one digit every `DISP_DIV` cycles, cycling 0→7 and wrapping.
- Reset asserted mid-entry discards the buffer and the password.

## Configuration
- `PASSWORD_LOCKOUT_EN` defined: the 3rd consecutive failure enters LOCKED, where all buttons and keys are ignored until reset.
- `PASSWORD_LOCKOUT_EN` undefined: LOCKED is unreachable. The failure count saturates at 3, and after a mismatch the FSM returns to ARMED with rled2=1.

## Test plan
- Reset, then check IDLE: LEDs all 0, `col`=1110, digit 7 shows 0.
- set_password pulse, three 150 ns presses with row=0111 (key codes 12+j), then enter → gled0=1 and the password equals the displayed buffer.
- test pulse, then the same three keys, then enter → gled1=1 and rled all 0.
- test pulse, then a wrong 3-digit entry, then enter → rled0=1, gled1=0, state ARMED. Repeating twice more gives rled2=1 and state LOCKED (macro on), or ARMED (macro off).
- A 40 ns press (below debounce) followed by two valid presses and enter → the short press is not captured, count=2, and enter is ignored.
- set_password asserted while OPEN → state SET, gled0=gled1=0, buffer cleared.

Source files
------------

// File: rtl/password_lock_top.sv
`default_nettype none
// ------------------------------------------------------------------------
// password_lock_top : 3-digit keypad lock, 4x4 scanner, 8-digit 7-seg, LEDs
// Optional macro PASSWORD_LOCKOUT_EN (lock after 3 failures). Rev 1.0
// ------------------------------------------------------------------------
module password_lock_top #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int DISP_DIV        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_password,
  input  logic       enter,
  input  logic       test,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] led_en,
  output logic       led_ca,
  output logic       led_cb,
  output logic       led_cc,
  output logic       led_cd,
  output logic       led_ce,
  output logic       led_cf,
  output logic       led_cg,
  output logic       led_dp,
  output logic       gled0,
  output logic       gled1,
  output logic       rled0,
  output logic       rled1,
  output logic       rled2
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DV_W = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SET    = 3'd1,
    S_ARMED  = 3'd2,
    S_TEST   = 3'd3,
    S_OPEN   = 3'd4,
    S_LOCKED = 3'd5
  } state_t;

  // ---------------- buttons ----------------
  logic [2:0] btn_q;
  logic [2:0] btn_qq;
  logic       set_rise;
  logic       test_rise;
  logic       enter_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q  <= 3'b000;
      btn_qq <= 3'b000;
    end else begin
      btn_q  <= {set_password, test, enter};
      btn_qq <= btn_q;
    end
  end

  assign set_rise   = btn_q[2] & ~btn_qq[2];
  assign test_rise  = btn_q[1] & ~btn_qq[1];
  assign enter_rise = btn_q[0] & ~btn_qq[0];

  // ---------------- keypad scanner ----------------
  logic [3:0]      row_q;
  logic [DB_W-1:0] db_cnt;
  logic            key_held;
  logic            key_valid;
  logic [3:0]      key_code;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic            row_idle;
  logic            row_stable;

  assign row_idle   = (row == 4'hF);
  assign row_stable = (row == row_q);

  always_comb begin
    row_idx = 2'd3;
    if (!row[0])      row_idx = 2'd0;
    else if (!row[1]) row_idx = 2'd1;
    else if (!row[2]) row_idx = 2'd2;
  end

  always_comb begin
    col_idx = 2'd3;
    if (!col[0])      col_idx = 2'd0;
    else if (!col[1]) col_idx = 2'd1;
    else if (!col[2]) col_idx = 2'd2;
  end

  // key_held covers the window from the issued event until the release has debounced
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= 4'b1110;
      row_q     <= 4'hF;
      db_cnt    <= '0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      row_q     <= row;
      key_valid <= 1'b0;
      if (!key_held) begin
        if (row_idle) begin
          col    <= {col[2:0], col[3]};
          db_cnt <= '0;
        end else if (!row_stable) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          key_valid <= 1'b1;
          key_code  <= {row_idx, col_idx};
          key_held  <= 1'b1;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        if (!row_idle || !row_stable) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          key_held <= 1'b0;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end
  end

  // ---------------- lock FSM ----------------
  state_t      state;
  logic [11:0] entry;
  logic [1:0]  entry_cnt;
  logic [11:0] password;
  logic [1:0]  fail_cnt;
  logic [1:0]  fail_inc;
  logic [2:0]  rled_q;

  assign fail_inc = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;

  function automatic logic [2:0] thermo(input logic [1:0] n);
    return {n == 2'd3, n >= 2'd2, n != 2'd0};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      entry     <= 12'h000;
      entry_cnt <= 2'd0;
      password  <= 12'h000;
      fail_cnt  <= 2'd0;
      rled_q    <= 3'b000;
      gled0     <= 1'b0;
      gled1     <= 1'b0;
    end else if (set_rise && state != S_LOCKED) begin
      state     <= S_SET;
      entry     <= 12'h000;
      entry_cnt <= 2'd0;
      gled0     <= 1'b0;
      gled1     <= 1'b0;
    end else if (test_rise && (state == S_ARMED || state == S_OPEN)) begin
      state     <= S_TEST;
      entry     <= 12'h000;
      entry_cnt <= 2'd0;
      gled0     <= 1'b1;
      gled1     <= 1'b0;
    end else if (enter_rise && entry_cnt == 2'd3 && state == S_SET) begin
      password <= entry;
      fail_cnt <= 2'd0;
      rled_q   <= 3'b000;
      state    <= S_ARMED;
      gled0    <= 1'b1;
      gled1    <= 1'b0;
    end else if (enter_rise && entry_cnt == 2'd3 && state == S_TEST) begin
      if (entry == password) begin
        state    <= S_OPEN;
        fail_cnt <= 2'd0;
        rled_q   <= 3'b000;
        gled0    <= 1'b1;
        gled1    <= 1'b1;
      end else begin
        fail_cnt <= fail_inc;
        rled_q   <= thermo(fail_inc);
`ifdef PASSWORD_LOCKOUT_EN
        if (fail_inc == 2'd3) begin
          state <= S_LOCKED;
          gled0 <= 1'b0;
          gled1 <= 1'b0;
        end else begin
          state <= S_ARMED;
          gled0 <= 1'b1;
          gled1 <= 1'b0;
        end
`else
        state <= S_ARMED;
        gled0 <= 1'b1;
        gled1 <= 1'b0;
`endif
      end
    end else if (key_valid && entry_cnt != 2'd3 && (state == S_SET || state == S_TEST)) begin
      entry     <= {entry[7:0], key_code};
      entry_cnt <= entry_cnt + 2'd1;
    end
  end

  assign rled0 = rled_q[0];
  assign rled1 = rled_q[1];
  assign rled2 = rled_q[2];

  // ---------------- display ----------------
  logic [DV_W-1:0] div_cnt;
  logic [2:0]      digit;
  logic [4:0]      disp_val;  // bit 4 set means blank
  logic [6:0]      seg_q;     // {g,f,e,d,c,b,a}, active-low

  function automatic logic [6:0] seg_font(input logic [4:0] v);
    logic [6:0] s;
    if (v[4]) return 7'h00;
    case (v[3:0])
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    disp_val = 5'h10;
    case (digit)
      3'd0:    if (entry_cnt > 2'd0) disp_val = {1'b0, entry[3:0]};
      3'd1:    if (entry_cnt > 2'd1) disp_val = {1'b0, entry[7:4]};
      3'd2:    if (entry_cnt > 2'd2) disp_val = {1'b0, entry[11:8]};
      3'd7:    disp_val = {2'b00, state};
      default: disp_val = 5'h10;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      digit   <= 3'd0;
      led_en  <= 8'hFE;
      seg_q   <= 7'h7F;
    end else begin
      if (div_cnt == DV_W'(DISP_DIV - 1)) begin
        div_cnt <= '0;
        digit   <= digit + 3'd1;
      end else begin
        div_cnt <= div_cnt + DV_W'(1);
      end
      led_en <= ~(8'b0000_0001 << digit);
      seg_q  <= ~seg_font(disp_val);
    end
  end

  assign led_ca = seg_q[0];
  assign led_cb = seg_q[1];
  assign led_cc = seg_q[2];
  assign led_cd = seg_q[3];
  assign led_ce = seg_q[4];
  assign led_cf = seg_q[5];
  assign led_cg = seg_q[6];
  assign led_dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_password_lock_top.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_password_lock_top : randomized bench with a queue-based lock model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_password_lock_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set_password = 1'b0;
  logic       enter = 1'b0;
  logic       test = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] led_en;
  logic       led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
  logic       gled0, gled1, rled0, rled1, rled2;

  logic key_down = 1'b0;
  int   key_i = 0;
  int   key_j = 0;

  int checks = 0;
  int failures = 0;

  // reference model
  int m_state = 0;
  int m_buf[$];
  int m_pw = 0;
  int m_fail = 0;
  logic [6:0] font_tab [0:15];

  always #5 clk = ~clk;

  // matrix keypad: the pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    if (key_down && col[key_j] == 1'b0) row[key_i] = 1'b0;
  end

  password_lock_top #(.DEBOUNCE_CYCLES(8), .DISP_DIV(4)) dut (
    .clk(clk), .rst(rst), .set_password(set_password), .enter(enter), .test(test),
    .row(row), .col(col), .led_en(led_en),
    .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
    .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp),
    .gled0(gled0), .gled1(gled1), .rled0(rled0), .rled1(rled1), .rled2(rled2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int buf_val();
    int v = 0;
    foreach (m_buf[k]) v = v * 16 + m_buf[k];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_buf.delete();
    m_pw = 0;
    m_fail = 0;
  endtask

  task automatic do_reset();
    key_down = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic press(input int i, input int j, input int len);
    @(negedge clk);
    key_i = i;
    key_j = j;
    key_down = 1'b1;
    repeat (len) @(negedge clk);
    key_down = 1'b0;
    repeat (25) @(negedge clk);
    if (len >= 15 && (m_state == 1 || m_state == 3) && m_buf.size() < 3)
      m_buf.push_back(4 * i + j);
  endtask

  // which: 0 set_password, 1 test, 2 enter
  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) set_password = 1'b1;
    else if (which == 1) test = 1'b1;
    else enter = 1'b1;
    repeat (2) @(negedge clk);
    set_password = 1'b0;
    test = 1'b0;
    enter = 1'b0;
    repeat (4) @(negedge clk);
    if (which == 0) begin
      if (m_state != 5) begin m_state = 1; m_buf.delete(); end
    end else if (which == 1) begin
      if (m_state == 2 || m_state == 4) begin m_state = 3; m_buf.delete(); end
    end else if (m_buf.size() == 3) begin
      if (m_state == 1) begin
        m_pw = buf_val();
        m_fail = 0;
        m_state = 2;
      end else if (m_state == 3) begin
        if (buf_val() == m_pw) begin
          m_state = 4;
          m_fail = 0;
        end else begin
          m_fail = (m_fail >= 3) ? 3 : m_fail + 1;
`ifdef PASSWORD_LOCKOUT_EN
          m_state = (m_fail == 3) ? 5 : 2;
`else
          m_state = 2;
`endif
        end
      end
    end
  endtask

  task automatic check_digit(input string tag, input int k, input int e);
    logic [7:0] want_en;
    logic [6:0] seg;
    bit ok;
    want_en = ~(8'b0000_0001 << k);
    ok = 1'b0;
    seg = 7'h00;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (led_en == want_en) begin
        seg = ~{led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    else check($sformatf("%s_dig%0d", tag, k), {25'd0, seg}, (e < 0) ? 32'd0 : {25'd0, font_tab[e]});
  endtask

  task automatic check_all(input string tag);
    int n;
    @(negedge clk);
    check({tag, "_gled0"}, {31'd0, gled0}, (m_state == 2 || m_state == 3 || m_state == 4) ? 32'd1 : 32'd0);
    check({tag, "_gled1"}, {31'd0, gled1}, (m_state == 4) ? 32'd1 : 32'd0);
    check({tag, "_rled"}, {29'd0, rled2, rled1, rled0},
          {29'd0, m_fail >= 3, m_fail >= 2, m_fail >= 1});
    check_digit(tag, 7, m_state);
    n = m_buf.size();
    for (int k = 0; k < 3; k++) check_digit(tag, k, (k < n) ? m_buf[n - 1 - k] : -1);
    check_digit(tag, 4, -1);
  endtask

  task automatic enter_code(input int v);
    for (int s = 2; s >= 0; s--) begin
      int d;
      d = (v >> (4 * s)) & 15;
      press(d / 4, d % 4, 15);
    end
  endtask

  initial begin
    font_tab[0] = 7'h3F;  font_tab[1] = 7'h06;  font_tab[2] = 7'h5B;  font_tab[3] = 7'h4F;
    font_tab[4] = 7'h66;  font_tab[5] = 7'h6D;  font_tab[6] = 7'h7D;  font_tab[7] = 7'h07;
    font_tab[8] = 7'h7F;  font_tab[9] = 7'h6F;  font_tab[10] = 7'h77; font_tab[11] = 7'h7C;
    font_tab[12] = 7'h39; font_tab[13] = 7'h5E; font_tab[14] = 7'h79; font_tab[15] = 7'h71;
    model_reset();

    // reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_col", {28'd0, col}, 32'hE);
    check("rst_en", {24'd0, led_en}, 32'hFE);
    check("rst_seg", {24'd0, led_dp, led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca}, 32'hFF);
    check("rst_leds", {27'd0, gled0, gled1, rled0, rled1, rled2}, 32'd0);
    rst = 1'b1;
    check_all("idle");

    // set password D E F via row 3
    pulse(0);
    press(3, 1, 15);
    press(3, 2, 15);
    press(3, 3, 15);
    check_all("set_buf");
    pulse(2);
    check_all("armed");

    // correct trial
    pulse(1);
    enter_code(m_pw);
    pulse(2);
    check_all("open");

    // set while open
    pulse(0);
    check_all("set_from_open");
    press(3, 1, 15);
    press(3, 2, 15);
    press(3, 3, 15);
    pulse(2);

    // three wrong trials
    for (int t = 0; t < 3; t++) begin
      pulse(1);
      press(3, 0, 15);
      press(3, 0, 15);
      press(3, 0, 15);
      pulse(2);
      check_all($sformatf("wrong%0d", t));
    end
    pulse(0);
    check_all("after_fails_set");
    do_reset();
    check_all("reset2");

    // short press is dropped, enter with two digits is ignored
    pulse(0);
    press(1, 2, 4);
    press(0, 1, 15);
    press(2, 3, 15);
    check_all("short_press");
    pulse(2);
    check_all("enter_cnt2");

    // reset mid-entry
    do_reset();
    check_all("reset_mid");

    // randomized traffic
    for (int it = 0; it < 50; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (m_state == 5 && r < 2) begin
        do_reset();
      end else if (r <= 3) begin
        press($urandom_range(0, 3), $urandom_range(0, 3), 15);
      end else if (r == 4) begin
        press($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(2, 5));
      end else if (r == 5) begin
        pulse(0);
      end else if (r == 6) begin
        pulse(1);
      end else if (r == 7) begin
        pulse(2);
      end else begin
        pulse(1);
        enter_code(m_pw);
        pulse(2);
      end
      check_all($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
